bist_sig_ctrl: RTL and testbench

- Test controller and signature checker on the response side of the BCD-adder BIST.
- Sequences one self-test run: asserts test mode, resets the cellular-automaton TPG and the MISR ORA, and lets exactly PATTERNS patterns through the CUT.
- Captures the 17-bit ORA signature, compares it against a golden value and reports pass/fail.
- Sits beside the BIST datapath: drives its tm and rst inputs and reads its oro output.

---
 rtl/bist_sig_ctrl.sv | 140 ++++++++++++++
 tb/tb_bist_sig_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_sig_ctrl.sv
// Response-side BIST controller: sequences one self-test run of the BCD-adder
// datapath, captures the ORA signature after PATTERNS absorptions and compares it to a golden value.
module bist_sig_ctrl #(
    parameter int unsigned PATTERNS = 1000,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SIG_W    = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] golden,
    input  logic [SIG_W-1:0] sig_in,
    output logic             tm,
    output logic             bist_rst,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] pat_cnt
);

    if ((PATTERNS < 1) || (64'(PATTERNS) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_patterns
        $error("bist_sig_ctrl: PATTERNS must lie in 1..2^CNT_W-1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PATTERNS - 1);
    localparam logic [CNT_W-1:0] FINAL_CNT = CNT_W'(PATTERNS);

    state_t             state_q;
    logic               tm_q;
    logic               bist_rst_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [SIG_W-1:0]   signature_q;
    logic [SIG_W-1:0]   golden_q;
    logic [CNT_W-1:0]   pat_cnt_q;

    // Run sequencer; every output is set together with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tm_q        <= 1'b0;
            bist_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            signature_q <= '0;
            golden_q    <= '0;
            pat_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_INIT;
                        golden_q   <= golden;
                        pat_cnt_q  <= '0;
                        tm_q       <= 1'b1;
                        bist_rst_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                S_INIT: begin
                    if (abort) begin
                        state_q    <= S_IDLE;
                        tm_q       <= 1'b0;
                        bist_rst_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                    end else begin
                        state_q    <= S_RUN;
                        bist_rst_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    // Counter saturates at PATTERNS so it never wraps.
                    if (abort) begin
                        state_q <= S_IDLE;
                        tm_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (pat_cnt_q == LAST_CNT) begin
                        state_q   <= S_CAPTURE;
                        pat_cnt_q <= FINAL_CNT;
                    end else begin
                        pat_cnt_q <= pat_cnt_q + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        tm_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        state_q     <= S_DONE;
                        signature_q <= sig_in;
                        pass_q      <= (sig_in == golden_q);
                        done_q      <= 1'b1;
                        tm_q        <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    tm_q       <= 1'b0;
                    bist_rst_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    pass_q     <= 1'b0;
                end
            endcase
        end
    end

    assign tm        = tm_q;
    assign bist_rst  = bist_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = signature_q;
    assign pat_cnt   = pat_cnt_q;

endmodule

// File: tb/tb_bist_sig_ctrl.sv
// Self-checking bench for bist_sig_ctrl with a behavioural CA-TPG / BCD-adder / MISR datapath
// around two controller instances (PATTERNS=4 and PATTERNS=1000).
module tb_bist_sig_ctrl;

    localparam int SIG_W = 17;
    localparam int CNT_W = 16;

    typedef struct {
        logic             pass;
        logic [SIG_W-1:0] sig;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        int               cyc;
        logic             tm;
        logic             br;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] cnt;
    } trow_t;

    logic clk = 1'b0;
    logic rst, start4, abort4, startk, abortk, fault_k;
    logic [SIG_W-1:0] gold4, goldk;
    logic [SIG_W-1:0] misr4, misrk;
    logic [8:0]       tpg4, tpgk;
    logic tm4, br4, busy4, done4, pass4, tmk, brk, busyk, donek, passk;
    logic [SIG_W-1:0] sg4, sgk;
    logic [CNT_W-1:0] cnt4, cntk;
    logic done4_prev, donek_prev;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t  q4[$];
    exp_t  qk[$];
    trow_t tbl[8];
    logic [SIG_W-1:0] g4, gk, gkf;

    always #5 clk = ~clk;

    bist_sig_ctrl #(.PATTERNS(4), .CNT_W(CNT_W), .SIG_W(SIG_W)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4), .golden(gold4), .sig_in(misr4),
        .tm(tm4), .bist_rst(br4), .busy(busy4), .done(done4), .pass(pass4),
        .signature(sg4), .pat_cnt(cnt4));

    bist_sig_ctrl #(.PATTERNS(1000), .CNT_W(CNT_W), .SIG_W(SIG_W)) u_dutk (
        .clk(clk), .rst(rst), .start(startk), .abort(abortk), .golden(goldk), .sig_in(misrk),
        .tm(tmk), .bist_rst(brk), .busy(busyk), .done(donek), .pass(passk),
        .signature(sgk), .pat_cnt(cntk));

    // Hybrid rule-90/150 cellular automaton with null boundaries.
    function automatic logic [8:0] ca_next(input logic [8:0] s);
        logic [8:0] r150 = 9'b1_0101_1011;
        logic [8:0] n;
        for (int i = 0; i < 9; i++) begin
            n[i] = ((i > 0) ? s[i-1] : 1'b0) ^ ((i < 8) ? s[i+1] : 1'b0) ^ (r150[i] & s[i]);
        end
        return n;
    endfunction

    // One-digit BCD adder: {cout, digit}; fault forces digit[0] low.
    function automatic logic [4:0] cut(input logic [8:0] p, input logic fault);
        logic [5:0] s;
        logic [4:0] r;
        s = 6'(p[3:0]) + 6'(p[7:4]) + 6'(p[8]);
        if (s > 6'd9) begin
            s = s + 6'd6;
            r = {1'b1, s[3:0]};
        end else begin
            r = {1'b0, s[3:0]};
        end
        if (fault) r[0] = 1'b0;
        return r;
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] m, input logic [4:0] r);
        logic [SIG_W-1:0] n;
        n = {m[SIG_W-2:0], 1'b0};
        if (m[SIG_W-1]) n = n ^ 17'h00009;
        return n ^ {12'd0, r};
    endfunction

    function automatic logic [SIG_W-1:0] ref_sig(input int n, input logic fault);
        logic [8:0]       t = 9'h1FF;
        logic [SIG_W-1:0] m = 17'h1FFFF;
        for (int i = 0; i < n; i++) begin
            m = misr_next(m, cut(t, fault));
            t = ca_next(t);
        end
        return m;
    endfunction

    // Datapath for the 4-pattern instance.
    always_ff @(posedge clk) begin
        if (br4) begin
            tpg4  <= 9'h1FF;
            misr4 <= 17'h1FFFF;
        end else if (tm4) begin
            misr4 <= misr_next(misr4, cut(tpg4, 1'b0));
            tpg4  <= ca_next(tpg4);
        end
    end

    // Datapath for the 1000-pattern instance, with optional sum[0] stuck-at-0.
    always_ff @(posedge clk) begin
        if (brk) begin
            tpgk  <= 9'h1FF;
            misrk <= 17'h1FFFF;
        end else if (tmk) begin
            misrk <= misr_next(misrk, cut(tpgk, fault_k));
            tpgk  <= ca_next(tpgk);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard for the 4-pattern instance: pop on each rising done.
    always @(negedge clk) begin
        done4_prev <= done4;
        if (done4 && !done4_prev) begin
            if (q4.size() == 0) begin
                chk("sb4_unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("sb4_pass", 32'(pass4), 32'(q4[0].pass));
                chk("sb4_signature", 32'(sg4), 32'(q4[0].sig));
                chk("sb4_pat_cnt", 32'(cnt4), 32'(q4[0].cnt));
                void'(q4.pop_front());
            end
        end
    end

    // Scoreboard for the 1000-pattern instance.
    always @(negedge clk) begin
        donek_prev <= donek;
        if (donek && !donek_prev) begin
            if (qk.size() == 0) begin
                chk("sbk_unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("sbk_pass", 32'(passk), 32'(qk[0].pass));
                chk("sbk_signature", 32'(sgk), 32'(qk[0].sig));
                chk("sbk_pat_cnt", 32'(cntk), 32'(qk[0].cnt));
                void'(qk.pop_front());
            end
        end
    end

    task automatic wait4(input int budget, input string nm);
        int n = 0;
        while (!done4 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(done4), 32'd1);
    endtask

    task automatic run4(input logic [SIG_W-1:0] g, input logic exp_pass, input string nm);
        gold4  = g;
        start4 = 1'b1;
        q4.push_back('{exp_pass, g4, 16'd4});
        @(negedge clk);
        start4 = 1'b0;
        wait4(20, nm);
    endtask

    task automatic runk(input logic flt, input logic exp_pass, input logic [SIG_W-1:0] exp_sig,
                        input string nm);
        int n = 0;
        fault_k = flt;
        goldk   = gk;
        startk  = 1'b1;
        qk.push_back('{exp_pass, exp_sig, 16'd1000});
        @(negedge clk);
        startk = 1'b0;
        while (!donek && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(donek), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // cycle, tm, bist_rst, busy, done, pat_cnt for a 4-pattern run started at edge 0
        tbl[0] = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[1] = '{2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[2] = '{3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[3] = '{4, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
        tbl[4] = '{5, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3};
        tbl[5] = '{6, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4};
        tbl[6] = '{7, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4};
        tbl[7] = '{8, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4};

        g4  = ref_sig(4, 1'b0);
        gk  = ref_sig(1000, 1'b0);
        gkf = ref_sig(1000, 1'b1);

        rst = 1'b1; start4 = 1'b0; abort4 = 1'b0; startk = 1'b0; abortk = 1'b0; fault_k = 1'b0;
        gold4 = '0; goldk = '0;
        repeat (3) @(negedge clk);
        chk("rst_tm", 32'(tm4), 32'd0);
        chk("rst_bist_rst", 32'(br4), 32'd0);
        chk("rst_busy", 32'({busy4, busyk}), 32'd0);
        chk("rst_done", 32'({done4, donek}), 32'd0);
        chk("rst_pass", 32'(pass4), 32'd0);
        chk("rst_signature", 32'(sg4), 32'd0);
        chk("rst_pat_cnt", 32'(cnt4), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cycle-accurate trace of a 4-pattern run.
        gold4  = g4;
        start4 = 1'b1;
        q4.push_back('{1'b1, g4, 16'd4});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            chk($sformatf("trace_c%0d_tm", tbl[i].cyc), 32'(tm4), 32'(tbl[i].tm));
            chk($sformatf("trace_c%0d_bist_rst", tbl[i].cyc), 32'(br4), 32'(tbl[i].br));
            chk($sformatf("trace_c%0d_busy", tbl[i].cyc), 32'(busy4), 32'(tbl[i].busy));
            chk($sformatf("trace_c%0d_done", tbl[i].cyc), 32'(done4), 32'(tbl[i].done));
            chk($sformatf("trace_c%0d_pat_cnt", tbl[i].cyc), 32'(cnt4), 32'(tbl[i].cnt));
        end

        // Wrong golden: fail, signature unchanged.
        run4(g4 ^ 17'd1, 1'b0, "bad_golden_timeout");

        // 1000-pattern runs: clean, then with sum[0] stuck-at-0.
        runk(1'b0, 1'b1, gk, "k_clean_timeout");
        runk(1'b1, 1'b0, gkf, "k_fault_timeout");

        // Abort in the third RUN cycle.
        gold4  = g4;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        chk("abort_tm", 32'(tm4), 32'd0);
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_done", 32'(done4), 32'd0);
        chk("abort_pass", 32'(pass4), 32'd0);
        chk("abort_pat_cnt", 32'(cnt4), 32'd2);
        chk("abort_signature_hold", 32'(sg4), 32'(g4));
        run4(g4, 1'b1, "after_abort_timeout");

        // start during RUN is ignored; start in DONE restarts.
        @(negedge clk);
        gold4  = g4;
        start4 = 1'b1;
        q4.push_back('{1'b1, g4, 16'd4});
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start4 = 1'b1;
        gold4  = ~g4;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midstart_c6_done", 32'(done4), 32'd0);
        @(negedge clk);
        chk("midstart_c7_done", 32'(done4), 32'd1);
        gold4  = g4;
        start4 = 1'b1;
        q4.push_back('{1'b1, g4, 16'd4});
        @(negedge clk);
        start4 = 1'b0;
        chk("restart_done_fall", 32'(done4), 32'd0);
        chk("restart_bist_rst", 32'(br4), 32'd1);
        wait4(20, "restart_timeout");

        // rst during CAPTURE, start held through reset release.
        @(negedge clk);
        gold4  = g4;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (5) @(negedge clk);
        chk("capture_busy", 32'(busy4), 32'd1);
        rst    = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        chk("rst_capture_done", 32'(done4), 32'd0);
        chk("rst_capture_pass", 32'(pass4), 32'd0);
        chk("rst_capture_signature", 32'(sg4), 32'd0);
        chk("rst_capture_tm", 32'(tm4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        q4.push_back('{1'b1, g4, 16'd4});
        @(negedge clk);
        start4 = 1'b0;
        chk("rst_release_bist_rst", 32'(br4), 32'd1);
        wait4(20, "rst_release_timeout");

        repeat (3) @(negedge clk);
        chk("sb4_drained", 32'(q4.size()), 32'd0);
        chk("sbk_drained", 32'(qk.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
